// File: rtl/bibus_arbiter.sv
// Round-robin arbiter and sequencer for the shared 8-bit bidirectional bus
// in front of the increment counter. Every tristate enable on the bus comes
// from here, and at most one of them is active in any cycle.
//
// state  | meaning
// IDLE   | bus released; pick a winner from req (round-robin from rr_ptr)
// DRIVE  | winner drives its byte; counter captures bus+1 on the closing edge
// RESULT | counter drives the result back; winner strobed via rd_valid
// GAP    | GAP_CYC turnaround cycles with no driver enabled
module bibus_arbiter #(
  parameter int NREQ    = 4,
  parameter int GAP_CYC = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [NREQ-1:0] mst_oe,
  output logic            cnt_oe,
  output logic [NREQ-1:0] rd_valid,
  output logic            busy,
  output logic [15:0]     txn_count
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    RESULT = 2'd2,
    GAP    = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [IW-1:0]   winner;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   pick;
  logic            pick_ok;
  logic [2:0]      gap_cnt;
  logic [15:0]     txn_q;
  logic [NREQ-1:0] win_oh;

  assign win_oh    = NREQ'(1) << winner;
  assign txn_count = txn_q;

  // Round-robin search: first requester at or above rr_ptr, wrapping around.
  always_comb begin
    int            idx;
    logic [IW-1:0] sel;
    pick    = '0;
    pick_ok = 1'b0;
    idx     = 0;
    sel     = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      sel = IW'(idx);
      if (!pick_ok && req[sel]) begin
        pick    = sel;
        pick_ok = 1'b1;
      end
    end
  end

  // State register; reset drops every enable immediately.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode; req is only looked at in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_ok) state_nxt = DRIVE;
      DRIVE:   state_nxt = RESULT;
      RESULT:  state_nxt = (GAP_CYC == 0) ? IDLE : GAP;
      GAP:     if (gap_cnt == 3'd0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Winner latch, round-robin pointer, gap down-counter and transaction count.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      winner  <= '0;
      rr_ptr  <= '0;
      gap_cnt <= '0;
      txn_q   <= '0;
    end else begin
      case (state)
        IDLE: if (pick_ok) winner <= pick;
        RESULT: begin
          txn_q   <= txn_q + 16'd1;
          rr_ptr  <= (winner == IW'(NREQ - 1)) ? '0 : winner + 1'b1;
          gap_cnt <= 3'(GAP_CYC - 1);
        end
        GAP: if (gap_cnt != 3'd0) gap_cnt <= gap_cnt - 3'd1;
        default: ;
      endcase
    end
  end

  // Output decode from state and the registered winner only (no req->oe path).
  always_comb begin
    gnt      = '0;
    mst_oe   = '0;
    cnt_oe   = 1'b0;
    rd_valid = '0;
    busy     = (state != IDLE);
    case (state)
      DRIVE: begin
        gnt    = win_oh;
        mst_oe = win_oh;
      end
      RESULT: begin
        gnt      = win_oh;
        cnt_oe   = 1'b1;
        rd_valid = win_oh;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bibus_arbiter.sv
// Bench for bibus_arbiter: four requesters and the increment counter sharing
// a resolved bus model, with a queue of expected results consumed on rd_valid.
module tb_bibus_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  req   = 4'h0;
  logic [3:0]  gnt;
  logic [3:0]  mst_oe;
  logic        cnt_oe;
  logic [3:0]  rd_valid;
  logic        busy;
  logic [15:0] txn_count;

  logic [7:0]  data [4];
  logic [7:0]  cnt_reg = 8'h00;
  logic [7:0]  bus;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int          idx;
    logic [7:0]  res;
    logic [15:0] cnt;
    int          spacing;
  } exp_t;

  exp_t        sbq[$];
  logic [15:0] exp_cnt = 16'h0000;

  bibus_arbiter #(.NREQ(4), .GAP_CYC(1)) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .gnt       (gnt),
    .mst_oe    (mst_oe),
    .cnt_oe    (cnt_oe),
    .rd_valid  (rd_valid),
    .busy      (busy),
    .txn_count (txn_count)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Resolved bus: whichever side is enabled drives it.
  always_comb begin
    bus = 8'h00;
    if (cnt_oe) bus = cnt_reg;
    else begin
      for (int i = 0; i < 4; i++)
        if (mst_oe[i]) bus = data[i];
    end
  end

  // Increment counter: captures bus+1 while a requester drives.
  always @(posedge clock) if (|mst_oe) cnt_reg <= bus + 8'd1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int idx, input logic [7:0] res, input int spacing);
    exp_t e;
    exp_cnt   = exp_cnt + 16'd1;
    e.idx     = idx;
    e.res     = res;
    e.cnt     = exp_cnt;
    e.spacing = spacing;
    sbq.push_back(e);
  endtask

  task automatic wait_rd(input string name, input int max);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clock);
      if (rd_valid != 4'h0) begin
        seen = 1'b1;
        break;
      end
    end
    chk({name, "_timeout"}, 32'(seen), 32'd1);
  endtask

  // Monitor: bus exclusivity every cycle, scoreboard pop on every rd_valid.
  initial begin
    logic [3:0]  prev_mst;
    logic [3:0]  oh;
    logic        pend;
    logic [15:0] pend_val;
    int          last_rd;
    exp_t        e;
    prev_mst = 4'h0;
    pend     = 1'b0;
    pend_val = 16'h0;
    last_rd  = 0;
    forever begin
      @(negedge clock);
      chk("exclusive_oe", 32'(($countones(mst_oe) + int'(cnt_oe)) <= 1), 32'd1);
      chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
      if (pend) begin
        chk("txn_count", 32'(txn_count), 32'(pend_val));
        pend = 1'b0;
      end
      if (rd_valid != 4'h0) begin
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_rd_valid: got 0x%0h expected none (t=%0t)", rd_valid, $time);
        end else begin
          e  = sbq.pop_front();
          oh = 4'b0001 << e.idx;
          chk("rd_valid", 32'(rd_valid), 32'(oh));
          chk("result_bus", 32'(bus), 32'(e.res));
          chk("gnt_in_result", 32'(gnt), 32'(oh));
          chk("drive_before_result", 32'(prev_mst), 32'(oh));
          if (e.spacing != 0) chk("txn_spacing", 32'(cyc - last_rd), 32'(e.spacing));
          last_rd  = cyc;
          pend     = 1'b1;
          pend_val = e.cnt;
        end
      end
      prev_mst = mst_oe;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    for (int i = 0; i < 4; i++) data[i] = 8'h00;

    // Reset held with all requests high: everything quiet.
    req = 4'hF;
    #12;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_mst_oe", 32'(mst_oe), 32'd0);
    chk("rst_cnt_oe", 32'(cnt_oe), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_txn_count", 32'(txn_count), 32'd0);
    @(negedge clock);
    req   = 4'h0;
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("idle_busy", 32'(busy), 32'd0);
    end

    // Single transaction from requester 0.
    data[0] = 8'h41;
    req     = 4'b0001;
    push(0, 8'h42, 0);
    wait_rd("t2", 10);
    req = 4'h0;
    repeat (3) @(negedge clock);

    // Requester 2 with 0xFF: result wraps to 0x00.
    data[2] = 8'hFF;
    req     = 4'b0100;
    push(2, 8'h00, 0);
    wait_rd("t3", 10);
    req = 4'h0;
    repeat (3) @(negedge clock);

    // Reset during DRIVE: enables drop asynchronously, transaction aborted.
    data[2] = 8'h55;
    req     = 4'b0100;
    seen    = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (mst_oe != 4'h0) begin
        seen = 1'b1;
        break;
      end
    end
    chk("t5_drive_timeout", 32'(seen), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("async_mst_oe", 32'(mst_oe), 32'd0);
    chk("async_gnt", 32'(gnt), 32'd0);
    chk("async_cnt_oe", 32'(cnt_oe), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_txn_count", 32'(txn_count), 32'd0);
    exp_cnt = 16'h0000;
    req     = 4'h0;
    repeat (2) @(negedge clock);
    reset = 1'b1;

    // All requesters held: order 0,1,2,3,0 at 4 cycles per transaction.
    data[0] = 8'h10;
    data[1] = 8'h20;
    data[2] = 8'h30;
    data[3] = 8'h40;
    req     = 4'hF;
    push(0, 8'h11, 0);
    push(1, 8'h21, 4);
    push(2, 8'h31, 4);
    push(3, 8'h41, 4);
    push(0, 8'h11, 4);
    for (int n = 0; n < 5; n++) wait_rd("t4", 10);
    req = 4'h0;
    repeat (3) @(negedge clock);

    // Counter wrap 0xFFFF -> 0x0000.
    force dut.txn_q = 16'hFFFF;
    #1;
    release dut.txn_q;
    #1;
    chk("preload_txn_count", 32'(txn_count), 32'h0000FFFF);
    exp_cnt = 16'hFFFF;
    data[1] = 8'h7F;
    req     = 4'b0010;
    push(1, 8'h80, 0);
    wait_rd("t6", 10);
    req = 4'h0;
    repeat (5) @(negedge clock);

    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
